rf_wport_arbiter: RTL and testbench
===================================

Name: rf_wport_arbiter

Overview:
Arbitrates the single register-file write port between the in-order writeback stage and a late-result source, such as a multi-cycle MDU or an out-of-band load return. Writeback results pass straight through with priority. Late results are buffered in a small FIFO and drain into idle write-port cycles. A starvation counter forces a pipeline stall so buffered results cannot wait forever. Writes to x0 are filtered out on both sources.

Parameters:
XLEN, 32, data width
BUF_DEPTH, 2, late-result FIFO entries (power of 2, >=2)
STARVE_MAX, 4, consecutive lost arbitrations before a forced stall (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
i_wb_RegDst  in  5  writeback destination register
i_wb_RegWrData  in  XLEN  writeback data
i_wb_RegWrEn  in  1  writeback write request
o_wb_stall  out  1  pipeline must hold writeback inputs stable this cycle
i_late_valid  in  1  late result valid
o_late_ready  out  1  late result accepted when valid&ready
i_late_RegDst  in  5  late destination
i_late_Data  in  XLEN  late data
o_RegDst  out  5  register-file write address
o_RegWrData  out  XLEN  register-file write data
o_RegWrEn  out  1  register-file write enable
o_late_cnt  out  clog2(BUF_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO is emptied; buffered entries are discarded, including on reset mid-operation.
  - Starvation counter = 0, o_wb_stall = 0, o_late_ready = 0, o_late_cnt = 0.
  - o_RegWrEn = 0, o_RegDst = 0, o_RegWrData = 0.
  - o_late_ready rises in the first cycle after reset is released.
- Effective writeback request: wb_req = i_wb_RegWrEn && (i_wb_RegDst != 0).
- o_late_ready = !full, registered-state only. It has no combinational dependence on this cycle's pop, so a full FIFO never accepts.
- Push: on i_late_valid && o_late_ready && i_late_RegDst != 0. Handshakes with destination 0 complete but push nothing.
- Winner selection, combinational from current inputs and state:
  - wb_req && !o_wb_stall: writeback wins. Outputs = wb inputs, o_RegWrEn = 1.
  - Otherwise, if FIFO is non-empty: head wins. Outputs = head, o_RegWrEn = 1, head pops at the clock edge.
  - Otherwise: o_RegWrEn = 0, o_RegDst = 0, o_RegWrData = 0.
- No bypass: a late result accepted in cycle N writes the register file no earlier than N+1.
- Same-cycle push and pop are allowed when not full. Occupancy is unchanged and order is strictly FIFO.
- Starvation counter, saturating, width clog2(STARVE_MAX+1):
  - +1 when the FIFO is non-empty and writeback wins.
  - Cleared when the head pops or the FIFO is empty.
- o_wb_stall = (counter == STARVE_MAX), decoded from registers only.
  - While stalled, the head wins even if wb_req = 1; the pipeline holds its writeback inputs.
  - The pop clears the counter, so stall lasts exactly one cycle per starvation event.
- Read pointers wrap modulo BUF_DEPTH. o_late_cnt ranges 0..BUF_DEPTH.
- Data path width is XLEN throughout. Destination fields are 5 bits and are not modified.

Test Plan:
1. Hold reset low, then release -> during reset o_RegWrEn=0, o_late_ready=0, o_wb_stall=0, o_late_cnt=0; the cycle after release o_late_ready=1. Repeat with reset asserted while o_late_cnt=2 -> cnt=0 and nothing is written afterwards.
2. Writeback dst=5, data=0xDEADBEEF, en=1 with FIFO empty -> same cycle o_RegWrEn=1, o_RegDst=5, o_RegWrData=0xDEADBEEF. Writeback dst=0, en=1 -> o_RegWrEn=0.
3. Late dst=7, data=0x11 accepted in cycle N with writeback idle -> cycle N o_RegWrEn=0; cycle N+1 o_RegDst=7, data=0x11, cnt back to 0.
4. Late dst=0 accepted -> o_late_cnt unchanged and no write. Writeback dst=0 en=1 while head is dst=3 -> head is written.
5. Buffer dst=9 data=0x99, then present writeback dst=4 every cycle -> four cycles write dst4, fifth cycle o_wb_stall=1 and dst9/0x99 is written, sixth cycle stall=0 and dst4 resumes.
6. BUF_DEPTH=2 with writeback busy every cycle, push dst 10 and 11 -> o_late_ready=0, third late (dst12) stays pending. Drain order must be 10, 11, 12, and ready reasserts the cycle after the first pop.

Source files
------------

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter
//   Shares the single register-file write port between the in-order writeback
//   stage and a late-result source (multi-cycle MDU, out-of-band load return).
//   Writeback passes straight through with priority. Late results are buffered
//   in a small FIFO and drain into idle write-port cycles. A saturating
//   starvation counter forces a one-cycle writeback stall so a buffered result
//   cannot wait forever. Writes to x0 are dropped on both sources.
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-low reset
//   i_wb_*             writeback request (destination, data, enable)
//   o_wb_stall         pipeline must hold its writeback inputs this cycle
//   i_late_* / o_late_ready  late-result valid/ready handshake
//   o_Reg*             register-file write port
//   o_late_cnt         FIFO occupancy, 0..BUF_DEPTH
module rf_wport_arbiter #(
    parameter  int XLEN       = 32,
    parameter  int BUF_DEPTH  = 2,
    parameter  int STARVE_MAX = 4,
    localparam int PTR_W      = $clog2(BUF_DEPTH),
    localparam int CNT_W      = $clog2(BUF_DEPTH) + 1,
    localparam int STV_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       i_wb_RegDst,
    input  logic [XLEN-1:0]  i_wb_RegWrData,
    input  logic             i_wb_RegWrEn,
    output logic             o_wb_stall,
    input  logic             i_late_valid,
    output logic             o_late_ready,
    input  logic [4:0]       i_late_RegDst,
    input  logic [XLEN-1:0]  i_late_Data,
    output logic [4:0]       o_RegDst,
    output logic [XLEN-1:0]  o_RegWrData,
    output logic             o_RegWrEn,
    output logic [CNT_W-1:0] o_late_cnt
);

    logic [4:0]      buf_dst_q  [BUF_DEPTH];
    logic [XLEN-1:0] buf_data_q [BUF_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [STV_W-1:0] starve_q, starve_d;
    // Low until the first clock edge after reset release, which keeps the
    // port quiet and the FIFO closed while reset is (or was just) asserted.
    logic             active_q, active_d;

    logic empty, full, wb_req, wb_win, push, pop;

    assign empty        = (cnt_q == '0);
    assign full         = (cnt_q == CNT_W'(BUF_DEPTH));
    assign o_late_ready = active_q && !full;
    assign o_wb_stall   = (starve_q == STV_W'(STARVE_MAX));
    assign o_late_cnt   = cnt_q;

    assign wb_req = active_q && i_wb_RegWrEn && (i_wb_RegDst != 5'd0);
    // Handshakes to x0 complete but never occupy a slot.
    assign push   = i_late_valid && o_late_ready && (i_late_RegDst != 5'd0);

    // NOTE: every output and internal signal gets a default before any branch,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        wb_win      = 1'b0;
        pop         = 1'b0;
        o_RegWrEn   = 1'b0;
        o_RegDst    = 5'd0;
        o_RegWrData = '0;
        if (wb_req && !o_wb_stall) begin
            wb_win      = 1'b1;
            o_RegWrEn   = 1'b1;
            o_RegDst    = i_wb_RegDst;
            o_RegWrData = i_wb_RegWrData;
        end else if (!empty) begin
            pop         = 1'b1;
            o_RegWrEn   = 1'b1;
            o_RegDst    = buf_dst_q[rd_ptr_q];
            o_RegWrData = buf_data_q[rd_ptr_q];
        end
    end

    always_comb begin
        active_d = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        starve_d = starve_q;
        if (pop || empty) begin
            starve_d = '0;
        end else if (wb_win && !o_wb_stall) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
        end else begin
            active_q <= active_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; entries are only
    // visible through cnt_q, which is reset, so stale contents are harmless.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_dst_q[wr_ptr_q]  <= i_late_RegDst;
            buf_data_q[wr_ptr_q] <= i_late_Data;
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
module tb_rf_wport_arbiter;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic        clk;
    logic        reset;
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    logic        wb_en;
    logic        stall;
    logic        late_valid;
    logic        late_ready;
    logic [4:0]  late_dst;
    logic [31:0] late_data;
    logic [4:0]  o_dst;
    logic [31:0] o_data;
    logic        o_en;
    logic [1:0]  o_cnt;

    int checks = 0;
    int errors = 0;

    rf_wport_arbiter #(.XLEN(XLEN), .BUF_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_wb_RegDst   (wb_dst),
        .i_wb_RegWrData(wb_data),
        .i_wb_RegWrEn  (wb_en),
        .o_wb_stall    (stall),
        .i_late_valid  (late_valid),
        .o_late_ready  (late_ready),
        .i_late_RegDst (late_dst),
        .i_late_Data   (late_data),
        .o_RegDst      (o_dst),
        .o_RegWrData   (o_data),
        .o_RegWrEn     (o_en),
        .o_late_cnt    (o_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wd, input logic [31:0] wdat,
                         input logic lv, input logic [4:0] ld, input logic [31:0] ldat);
        wb_en      = we;
        wb_dst     = wd;
        wb_data    = wdat;
        late_valid = lv;
        late_dst   = ld;
        late_data  = ldat;
    endtask

    task automatic check_outs(input string tag, input logic e_en, input logic [4:0] e_dst,
                              input logic [31:0] e_data, input logic e_ready,
                              input logic e_stall, input logic [1:0] e_cnt);
        check({tag, ".en"},    o_en,       e_en);
        check({tag, ".dst"},   o_dst,      e_dst);
        check({tag, ".data"},  o_data,     e_data);
        check({tag, ".ready"}, late_ready, e_ready);
        check({tag, ".stall"}, stall,      e_stall);
        check({tag, ".cnt"},   o_cnt,      e_cnt);
    endtask

    typedef struct {
        logic        wb_en;
        logic [4:0]  wb_dst;
        logic [31:0] wb_data;
        logic        lv;
        logic [4:0]  ld;
        logic [31:0] ldat;
        logic        e_en;
        logic [4:0]  e_dst;
        logic [31:0] e_data;
        logic        e_ready;
        logic        e_stall;
        logic [1:0]  e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [4:0] wd, input logic [31:0] wdat,
                                input logic lv, input logic [4:0] ld, input logic [31:0] ldat,
                                input logic ee, input logic [4:0] ed, input logic [31:0] edat,
                                input logic er, input logic es, input logic [1:0] ec);
        vec_t v;
        v.wb_en = we;  v.wb_dst = wd; v.wb_data = wdat;
        v.lv = lv;     v.ld = ld;     v.ldat = ldat;
        v.e_en = ee;   v.e_dst = ed;  v.e_data = edat;
        v.e_ready = er; v.e_stall = es; v.e_cnt = ec;
        return v;
    endfunction

    // Reference model: FIFO as a queue, starvation as an integer count.
    typedef struct {
        logic [4:0]  dst;
        logic [31:0] data;
    } entry_t;

    entry_t mq[$];
    int     m_starve;

    vec_t vecs[$];

    initial begin
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        reset = 1'b0;

        // Reset state, including a writeback request presented during reset.
        repeat (2) @(negedge clk);
        drive(1'b1, 5'd5, 32'hCAFE_0001, 1'b1, 5'd6, 32'h66);
        #1;
        check_outs("reset", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("reset.ready_after_release", late_ready, 1'b1);
        check("reset.cnt_after_release", o_cnt, 2'd0);

        // Directed table: pass-through, x0 filtering, no-bypass, starvation stall.
        vecs.push_back(mk(1, 5,  32'hDEADBEEF, 0, 0, 0,      1, 5, 32'hDEADBEEF, 1, 0, 0));
        vecs.push_back(mk(1, 0,  32'h123,      0, 0, 0,      0, 0, 0,            1, 0, 0));
        vecs.push_back(mk(0, 0,  0,            1, 7, 32'h11, 0, 0, 0,            1, 0, 0));
        vecs.push_back(mk(0, 0,  0,            0, 0, 0,      1, 7, 32'h11,       1, 0, 1));
        vecs.push_back(mk(0, 0,  0,            0, 0, 0,      0, 0, 0,            1, 0, 0));
        vecs.push_back(mk(0, 0,  0,            1, 0, 32'h55, 0, 0, 0,            1, 0, 0));
        vecs.push_back(mk(0, 0,  0,            0, 0, 0,      0, 0, 0,            1, 0, 0));
        vecs.push_back(mk(1, 0,  32'h77,       1, 3, 32'h33, 0, 0, 0,            1, 0, 0));
        vecs.push_back(mk(1, 0,  32'h77,       0, 0, 0,      1, 3, 32'h33,       1, 0, 1));
        vecs.push_back(mk(0, 0,  0,            0, 0, 0,      0, 0, 0,            1, 0, 0));
        vecs.push_back(mk(0, 0,  0,            1, 9, 32'h99, 0, 0, 0,            1, 0, 0));
        for (int i = 0; i < SMAX; i++)
            vecs.push_back(mk(1, 4, 32'h44,    0, 0, 0,      1, 4, 32'h44,       1, 0, 1));
        vecs.push_back(mk(1, 4,  32'h44,       0, 0, 0,      1, 9, 32'h99,       1, 1, 1));
        vecs.push_back(mk(1, 4,  32'h44,       0, 0, 0,      1, 4, 32'h44,       1, 0, 0));
        vecs.push_back(mk(0, 0,  0,            0, 0, 0,      0, 0, 0,            1, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].wb_en, vecs[i].wb_dst, vecs[i].wb_data,
                  vecs[i].lv, vecs[i].ld, vecs[i].ldat);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].e_en, vecs[i].e_dst, vecs[i].e_data,
                       vecs[i].e_ready, vecs[i].e_stall, vecs[i].e_cnt);
            @(negedge clk);
        end

        // Full FIFO under constant writeback pressure: ordering and ready timing.
        begin
            int pend[$];
            int drained[$];
            int first_pop;
            pend      = '{10, 11, 12};
            first_pop = -1;
            for (int cyc = 0; cyc < 60 && drained.size() < 3; cyc++) begin
                if (pend.size() > 0)
                    drive(1'b1, 5'd1, 32'hA, 1'b1, 5'(pend[0]), 32'h100 + 32'(pend[0]));
                else
                    drive(1'b1, 5'd1, 32'hA, 1'b0, 5'd0, 32'd0);
                #1;
                if (cyc == 2)
                    check("full.ready_low", late_ready, 1'b0);
                if (first_pop >= 0 && cyc == first_pop + 1)
                    check("full.ready_after_pop", late_ready, 1'b1);
                if (o_en && o_dst != 5'd1) begin
                    check($sformatf("full.data%0d", drained.size()), o_data, 32'h100 + 32'(o_dst));
                    check($sformatf("full.stall%0d", drained.size()), stall, 1'b1);
                    drained.push_back(int'(o_dst));
                    if (first_pop < 0) first_pop = cyc;
                end
                if (late_valid && late_ready) void'(pend.pop_front());
                @(negedge clk);
            end
            check("full.drained", drained.size(), 3);
            for (int i = 0; i < drained.size() && i < 3; i++)
                check($sformatf("full.order%0d", i), drained[i], 10 + i);
        end

        // Reset with two entries buffered: they must vanish.
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (2) @(negedge clk);
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd20, 32'h200);
        @(negedge clk);
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd21, 32'h201);
        @(negedge clk);
        drive(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'd0);
        #1;
        check("midrst.cnt_before", o_cnt, 2'd2);
        #2;
        reset = 1'b0;
        #1;
        check("midrst.cnt", o_cnt, 2'd0);
        check("midrst.en", o_en, 1'b0);
        check("midrst.ready", late_ready, 1'b0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("midrst.idle%0d", i), o_en, 1'b0);
        end
        check("midrst.cnt_after", o_cnt, 2'd0);

        // Randomised traffic against the queue model.
        m_starve = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic        m_ready, m_stall, m_wbreq, m_en, popping, wbwon, was_empty;
            logic [4:0]  m_dst, rd;
            logic [31:0] m_data;
            rd = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) rd = 5'd0;
            drive(($urandom_range(0, 99) < 60), rd, $urandom,
                  ($urandom_range(0, 99) < 40), 5'($urandom_range(0, 31)), $urandom);
            if ($urandom_range(0, 7) == 0) late_dst = 5'd0;
            #1;
            m_ready = (mq.size() < DEPTH);
            m_stall = (m_starve == SMAX);
            m_wbreq = wb_en && (wb_dst != 5'd0);
            popping = 1'b0;
            wbwon   = 1'b0;
            m_en    = 1'b0;
            m_dst   = 5'd0;
            m_data  = 32'd0;
            if (m_wbreq && !m_stall) begin
                wbwon = 1'b1; m_en = 1'b1; m_dst = wb_dst; m_data = wb_data;
            end else if (mq.size() > 0) begin
                popping = 1'b1; m_en = 1'b1; m_dst = mq[0].dst; m_data = mq[0].data;
            end
            check_outs($sformatf("rnd%0d", cyc), m_en, m_dst, m_data, m_ready, m_stall,
                       2'(mq.size()));
            was_empty = (mq.size() == 0);
            if (popping) void'(mq.pop_front());
            if (late_valid && m_ready && late_dst != 5'd0)
                mq.push_back('{dst: late_dst, data: late_data});
            if (popping || was_empty) m_starve = 0;
            else if (wbwon && m_starve < SMAX) m_starve++;
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
